// File: rtl/mem_router.sv
// mem_router: decodes the execute-stage address and steers store data and
// byte-enables to DMEM, IMEM or MMIO; issues reads to DMEM/BIOS/MMIO and
// returns the selected word one cycle later. Also owns the UART TX holding
// register, the RX pop strobe and the cycle / retired-instruction counters.
module mem_router #(
  parameter int DMEM_AWIDTH = 14,
  parameter int IMEM_AWIDTH = 14,
  parameter int BIOS_AWIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr,
  input  logic [3:0]             wen,
  input  logic [31:0]            wdata,
  input  logic                   is_load,
  input  logic                   pc30,
  input  logic                   stall,
  input  logic                   inst_retire,
  output logic                   dmem_en,
  output logic [3:0]             dmem_we,
  output logic [DMEM_AWIDTH-1:0] dmem_addr,
  output logic [31:0]            dmem_din,
  input  logic [31:0]            dmem_dout,
  output logic [BIOS_AWIDTH-1:0] bios_addr,
  input  logic [31:0]            bios_dout,
  output logic [3:0]             imem_we,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  output logic [31:0]            imem_din,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_valid,
  input  logic                   uart_tx_ready,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_valid,
  output logic                   uart_rx_ready,
  output logic [31:0]            rdata
);

  // Region of the current address; also the form in which the read select is held.
  typedef enum logic [2:0] {
    RGN_NONE = 3'd0,
    RGN_DMEM = 3'd1,
    RGN_BIOS = 3'd2,
    RGN_IMEM = 3'd3,
    RGN_MMIO = 3'd4
  } region_t;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  region_t     region;
  logic        access;
  logic        is_store;
  logic        mmio_store;
  logic        mmio_load;
  logic        tx_store;
  logic        cnt_clear;
  logic [7:0]  mmio_off;
  logic [31:0] mmio_word;

  // Read select: region of the last captured load plus the MMIO word sampled
  // at capture time, so MMIO reads line up with the synchronous RAMs.
  region_t     sel_region_reg;
  logic [31:0] mmio_rdata_reg;

  logic        tx_full_reg;
  logic [7:0]  tx_data_reg;
  logic [31:0] cycle_cnt_reg;
  logic [31:0] inst_cnt_reg;

  // Address bits outside every decoded field are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  // Decode the top nibble into a region; anything unlisted is unmapped.
  always_comb begin
    region = RGN_NONE;
    case (addr[31:28])
      4'b0001: region = RGN_DMEM;
      4'b0100: region = RGN_BIOS;
      4'b0010: region = RGN_IMEM;
      4'b1000: region = RGN_MMIO;
      default: region = RGN_NONE;
    endcase
  end

  // Side effects are suppressed while frozen and while reset is held.
  assign access     = ~stall & ~rst;
  assign is_store   = |wen;
  assign mmio_off   = addr[7:0];
  assign mmio_store = (region == RGN_MMIO) & access & is_store;
  assign mmio_load  = (region == RGN_MMIO) & access & is_load;
  assign tx_store   = mmio_store & (mmio_off == OFF_TX);
  assign cnt_clear  = mmio_store & (mmio_off == OFF_CLEAR);

  // Memory-side address and data fan-out; BIOS is always addressed.
  assign dmem_addr = addr[DMEM_AWIDTH+1:2];
  assign imem_addr = addr[IMEM_AWIDTH+1:2];
  assign bios_addr = addr[BIOS_AWIDTH+1:2];
  assign dmem_din  = wdata;
  assign imem_din  = wdata;

  // Access enables: DMEM for loads and stores, IMEM writes only from PC[30]=1 code.
  assign dmem_en = (region == RGN_DMEM) & access & (is_load | is_store);
  assign dmem_we = ((region == RGN_DMEM) & access) ? wen : 4'b0000;
  assign imem_we = ((region == RGN_IMEM) & access & pc30) ? wen : 4'b0000;

  // Pop the RX byte only when a load actually consumes a valid byte.
  assign uart_rx_ready = mmio_load & (mmio_off == OFF_RX) & uart_rx_valid;

  assign uart_tx_valid = tx_full_reg;
  assign uart_tx_data  = tx_data_reg;

  // MMIO read value for the current offset; undefined offsets read as zero.
  always_comb begin
    mmio_word = 32'h0000_0000;
    case (mmio_off)
      OFF_STATUS: mmio_word = {30'b0, uart_rx_valid, ~tx_full_reg};
      OFF_RX:     mmio_word = {24'b0, uart_rx_data};
      OFF_CYCLE:  mmio_word = cycle_cnt_reg;
      OFF_INST:   mmio_word = inst_cnt_reg;
      default:    mmio_word = 32'h0000_0000;
    endcase
  end

  // Capture the read select on every unstalled load; hold it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_region_reg <= RGN_NONE;
      mmio_rdata_reg <= 32'h0000_0000;
    end else if (is_load & ~stall) begin
      sel_region_reg <= region;
      mmio_rdata_reg <= (region == RGN_MMIO) ? mmio_word : 32'h0000_0000;
    end
  end

  // Return the word for the captured region; IMEM is write-only so reads as zero.
  always_comb begin
    rdata = 32'h0000_0000;
    case (sel_region_reg)
      RGN_DMEM: rdata = dmem_dout;
      RGN_BIOS: rdata = bios_dout;
      RGN_MMIO: rdata = mmio_rdata_reg;
      default:  rdata = 32'h0000_0000;
    endcase
  end

  // TX holding register: drain on handshake first, accept a new byte only when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_full_reg <= 1'b0;
      tx_data_reg <= 8'h00;
    end else if (tx_full_reg) begin
      if (uart_tx_ready) begin
        tx_full_reg <= 1'b0;
      end
    end else if (tx_store) begin
      tx_full_reg <= 1'b1;
      tx_data_reg <= wdata[7:0];
    end
  end

  // Free-running cycle counter and retired-instruction counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg <= 32'h0000_0000;
      inst_cnt_reg  <= 32'h0000_0000;
    end else if (cnt_clear) begin
      cycle_cnt_reg <= 32'h0000_0000;
      inst_cnt_reg  <= 32'h0000_0000;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      inst_cnt_reg  <= inst_cnt_reg + {31'b0, inst_retire};
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed sequences for the multi-cycle
// cases, a table of decode vectors, and randomized traffic against a
// behavioural reference model of the memory map, TX register and counters.
module tb_mem_router;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        is_load;
  logic        pc30;
  logic        stall;
  logic        inst_retire;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [3:0]  imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [31:0] rdata;

  int checks;
  int failures;

  mem_router #(.DMEM_AWIDTH(14), .IMEM_AWIDTH(14), .BIOS_AWIDTH(12)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
    .is_load(is_load), .pc30(pc30), .stall(stall), .inst_retire(inst_retire),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .bios_addr(bios_addr), .bios_dout(bios_dout),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memories driven by the DUT's own outputs.
  logic [31:0] env_dmem [0:16383];
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_dout <= env_dmem[dmem_addr];
      for (int b = 0; b < 4; b++)
        if (dmem_we[b]) env_dmem[dmem_addr][b*8 +: 8] = dmem_din[b*8 +: 8];
    end
  end
  always @(posedge clk) bios_dout <= 32'hB105_0000 ^ {20'b0, bios_addr};

  // Reference model driven only by the bench's inputs.
  logic [31:0] m_dmem [0:16383];
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  logic        m_full;
  logic [7:0]  m_txd;

  function automatic logic mmio_wr(input logic [7:0] off);
    return (addr[31:28] == 4'h8) && (addr[7:0] == off) && (wen != 4'h0) && !stall;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_inst = 0; m_full = 0; m_txd = 0;
    end else begin
      if (mmio_wr(8'h18)) begin
        m_cyc = 0; m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1;
        m_inst = m_inst + (inst_retire ? 1 : 0);
      end
      if (m_full && uart_tx_ready) m_full = 0;
      else if (!m_full && mmio_wr(8'h08)) begin m_full = 1; m_txd = wdata[7:0]; end
      if (addr[31:28] == 4'h1 && !stall && wen != 4'h0)
        for (int b = 0; b < 4; b++)
          if (wen[b]) m_dmem[addr[15:2]][b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  function automatic logic [31:0] exp_read();
    case (addr[31:28])
      4'h1: return m_dmem[addr[15:2]];
      4'h4: return 32'hB105_0000 ^ {20'b0, addr[13:2]};
      4'h8: case (addr[7:0])
              8'h00: return {30'b0, uart_rx_valid, !m_full};
              8'h04: return {24'b0, uart_rx_data};
              8'h10: return m_cyc;
              8'h14: return m_inst;
              default: return 32'h0;
            endcase
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d, input logic ld);
    addr = a; wen = w; wdata = d; is_load = ld;
  endtask

  task automatic idle();
    set_in(32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  w;
    logic        ld;
    logic        p30;
    logic        stl;
    logic        en;
    logic [3:0]  dwe;
    logic [3:0]  iwe;
  } vec_t;
  vec_t vecs [10];

  logic [7:0]  offs [7];
  logic [3:0]  unm [4];
  logic        pend;
  logic [31:0] pend_val;
  logic [3:0]  hi;

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16384; i++) begin env_dmem[i] = 0; m_dmem[i] = 0; end
    rst = 1'b1; idle(); pc30 = 0; stall = 0; inst_retire = 0;
    uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
    #3;
    check("reset_rdata", rdata, 32'h0);
    check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("reset_tx_data", {24'b0, uart_tx_data}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: DMEM store then load
    set_in(32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("t1_dmem_we", {28'b0, dmem_we}, 32'hF);
    check("t1_dmem_en", {31'b0, dmem_en}, 32'h1);
    tick();
    set_in(32'h1000_0010, 4'h0, 32'h0, 1);
    tick(); idle();
    @(negedge clk);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);
    tick();

    // 2: IMEM store gated by pc30
    set_in(32'h2000_0004, 4'h4, 32'h1234_5678, 0); pc30 = 0;
    @(negedge clk);
    check("t2_imem_we_pc0", {28'b0, imem_we}, 32'h0);
    tick(); pc30 = 1;
    @(negedge clk);
    check("t2_imem_we_pc1", {28'b0, imem_we}, 32'h4);
    check("t2_dmem_we", {28'b0, dmem_we}, 32'h0);
    tick(); pc30 = 0; idle();

    // 3: TX hold, store during hold dropped, handshake + store dropped
    uart_tx_ready = 0;
    set_in(32'h8000_0008, 4'h1, 32'h41, 0);
    @(negedge clk);
    check("t3_valid_before", {31'b0, uart_tx_valid}, 32'h0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) set_in(32'h8000_0008, 4'h1, 32'h42, 0); else idle();
      @(negedge clk);
      check("t3_valid_hold", {31'b0, uart_tx_valid}, 32'h1);
      check("t3_data_hold", {24'b0, uart_tx_data}, 32'h41);
      tick();
    end
    uart_tx_ready = 1; set_in(32'h8000_0008, 4'h1, 32'h43, 0);
    @(negedge clk);
    check("t3_valid_c4", {31'b0, uart_tx_valid}, 32'h1);
    tick(); uart_tx_ready = 0; idle();
    @(negedge clk);
    check("t3_valid_cleared", {31'b0, uart_tx_valid}, 32'h0);
    check("t3_data_kept", {24'b0, uart_tx_data}, 32'h41);
    tick();
    set_in(32'h8000_0008, 4'h1, 32'h44, 0);
    tick(); idle();
    @(negedge clk);
    check("t3_new_data", {24'b0, uart_tx_data}, 32'h44);
    uart_tx_ready = 1; tick(); uart_tx_ready = 0;

    // 4: RX pop, stalled load has no side effects
    uart_rx_valid = 1; uart_rx_data = 8'h5A;
    set_in(32'h8000_0004, 4'h0, 32'h0, 1);
    @(negedge clk);
    check("t4_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    tick(); idle();
    @(negedge clk);
    check("t4_rx_ready_off", {31'b0, uart_rx_ready}, 32'h0);
    check("t4_rdata", rdata, 32'h5A);
    tick();
    stall = 1; uart_rx_data = 8'h77; set_in(32'h8000_0004, 4'h0, 32'h0, 1);
    @(negedge clk);
    check("t4_stall_no_pulse", {31'b0, uart_rx_ready}, 32'h0);
    tick(); stall = 0; idle();
    @(negedge clk);
    check("t4_stall_held", rdata, 32'h5A);
    set_in(32'h8000_0000, 4'h0, 32'h0, 1);
    tick(); idle();
    check("t4_status", rdata, 32'h3);
    uart_rx_valid = 0;

    // 5: counters
    #2 rst = 1; @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 10; i++) begin inst_retire = (i < 4); tick(); end
    inst_retire = 0;
    set_in(32'h8000_0010, 4'h0, 32'h0, 1); tick();
    check("t5_cycle", rdata, 32'd10);
    set_in(32'h8000_0014, 4'h0, 32'h0, 1); tick();
    check("t5_inst", rdata, 32'd4);
    set_in(32'h8000_0018, 4'hF, 32'h0, 0); tick();
    set_in(32'h8000_0010, 4'h0, 32'h0, 1); tick();
    check("t5_cycle_clr", rdata, 32'd0);
    set_in(32'h8000_0014, 4'h0, 32'h0, 1); tick();
    check("t5_inst_clr", rdata, 32'd0);
    set_in(32'h8000_0010, 4'h0, 32'h0, 1); tick();
    check("t5_cycle_resume", rdata, 32'd2);
    idle();

    // 6: async reset mid-transfer
    set_in(32'h8000_0008, 4'h1, 32'h41, 0); tick();
    set_in(32'h1000_0010, 4'h0, 32'h0, 1); tick(); idle();
    check("t6_pre_rdata", rdata, 32'hDEAD_BEEF);
    check("t6_pre_valid", {31'b0, uart_tx_valid}, 32'h1);
    #2 rst = 1; set_in(32'h1000_0010, 4'hF, 32'h0, 0);
    #1;
    check("t6_rst_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("t6_rst_data", {24'b0, uart_tx_data}, 32'h0);
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_dmem_we", {28'b0, dmem_we}, 32'h0);
    check("t6_rst_dmem_en", {31'b0, dmem_en}, 32'h0);
    set_in(32'h2000_0000, 4'hF, 32'h0, 0); pc30 = 1;
    #1;
    check("t6_rst_imem_we", {28'b0, imem_we}, 32'h0);
    pc30 = 0; @(posedge clk); #1 rst = 0; idle();
    set_in(32'h1000_0010, 4'h0, 32'h0, 1); tick();
    check("t6_dmem_again", rdata, 32'hDEAD_BEEF);
    set_in(32'h3000_0000, 4'h0, 32'h0, 1); tick(); idle();
    check("t6_unmapped", rdata, 32'h0);

    // Decode vector table
    vecs[0] = '{32'h1000_0020, 4'hF, 0, 0, 0, 1, 4'hF, 4'h0};
    vecs[1] = '{32'h1000_0024, 4'h3, 0, 0, 1, 0, 4'h0, 4'h0};
    vecs[2] = '{32'h1000_0028, 4'h0, 1, 0, 0, 1, 4'h0, 4'h0};
    vecs[3] = '{32'h1000_0028, 4'h0, 1, 0, 1, 0, 4'h0, 4'h0};
    vecs[4] = '{32'h2000_0010, 4'hC, 0, 1, 0, 0, 4'h0, 4'hC};
    vecs[5] = '{32'h2000_0010, 4'hC, 0, 0, 0, 0, 4'h0, 4'h0};
    vecs[6] = '{32'h2000_0010, 4'h5, 0, 1, 1, 0, 4'h0, 4'h0};
    vecs[7] = '{32'h4000_0000, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0};
    vecs[8] = '{32'h3000_0000, 4'hF, 0, 1, 0, 0, 4'h0, 4'h0};
    vecs[9] = '{32'h1000_0000, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0};
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].a, vecs[i].w, 32'hA5A5_0000 + i, vecs[i].ld);
      pc30 = vecs[i].p30; stall = vecs[i].stl;
      @(negedge clk);
      check("vec_dmem_en", {31'b0, dmem_en}, {31'b0, vecs[i].en});
      check("vec_dmem_we", {28'b0, dmem_we}, {28'b0, vecs[i].dwe});
      check("vec_imem_we", {28'b0, imem_we}, {28'b0, vecs[i].iwe});
      tick();
    end
    idle(); pc30 = 0; stall = 0;
    tick();

    // Randomized traffic against the reference model
    offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h10;
    offs[4] = 8'h14; offs[5] = 8'h18; offs[6] = 8'h0C;
    unm[0] = 4'h0; unm[1] = 4'h3; unm[2] = 4'hF; unm[3] = 4'h5;
    pend = 0; pend_val = 0;
    for (int n = 0; n < 400; n++) begin
      int r, op;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      op = $urandom_range(0, 2);
      if (r <= 2)      a = 32'h1000_0000 | ($urandom_range(0, 15) << 2);
      else if (r == 3) a = 32'h4000_0000 | ($urandom & 32'h0000_3FFC);
      else if (r == 4) a = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
      else if (r <= 7) a = 32'h8000_0000 | {24'b0, offs[$urandom_range(0, 6)]};
      else             a = {unm[$urandom_range(0, 3)], 28'b0} | ($urandom & 32'h0000_FFFC);
      if (op == 1)      set_in(a, 4'h0, 32'h0, 1);
      else if (op == 2) set_in(a, 4'($urandom_range(1, 15)), $urandom, 0);
      else              set_in(a, 4'h0, $urandom, 0);
      stall = ($urandom_range(0, 4) == 0);
      pc30 = 1'($urandom_range(0, 1));
      inst_retire = 1'($urandom_range(0, 1));
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_rx_data = 8'($urandom);
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      hi = addr[31:28];
      check("rnd_dmem_en", {31'b0, dmem_en},
            {31'b0, (hi == 4'h1) && !stall && (is_load || wen != 0)});
      check("rnd_dmem_we", {28'b0, dmem_we}, {28'b0, ((hi == 4'h1) && !stall) ? wen : 4'h0});
      check("rnd_imem_we", {28'b0, imem_we}, {28'b0, ((hi == 4'h2) && pc30 && !stall) ? wen : 4'h0});
      check("rnd_rx_ready", {31'b0, uart_rx_ready},
            {31'b0, (hi == 4'h8) && (addr[7:0] == 8'h04) && is_load && !stall && uart_rx_valid});
      check("rnd_tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_full});
      check("rnd_tx_data", {24'b0, uart_tx_data}, {24'b0, m_txd});
      if (pend) check("rnd_rdata", rdata, pend_val);
      pend = is_load && !stall;
      pend_val = exp_read();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
